i2c_target: RTL and testbench

I2C target (slave) responder for the board's pulled-up SCL/SDA pins. It gives an external I2C controller byte-addressed read/write access to an 8-bit register space, so that motor-control status and configuration are reachable over I2C. The block sits in the `clk` domain (12 MHz) behind the SB_IO pull-up input buffers. It drives SDA open-drain through an external tristate.

---
 rtl/i2c_target.sv | 234 +++++++++++++++++++++++
 tb/tb_i2c_target.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// i2c_target: I2C target responder giving an external controller byte-addressed
// read/write access to an 8-bit register space.
//
// Ports:
//   clk        system clock (12 MHz), all logic on the rising edge
//   reset      synchronous active-high reset
//   scl_in     raw SCL pad input (asynchronous)
//   sda_in     raw SDA pad input (asynchronous)
//   sda_oe     1 = pull SDA low, 0 = release; SCL is never driven
//   reg_addr   register pointer
//   reg_wdata  last received data byte
//   reg_we     one-cycle write strobe (reg_addr/reg_wdata valid with it)
//   reg_rdata  read data for reg_addr, sampled the cycle after reg_re
//   reg_re     one-cycle read strobe ahead of each transmitted byte
//   busy       high from an address-matched START until STOP/next START
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       reg_re,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RLOAD, S_RDATA, S_RACK
    } state_t;

    // Two-flop synchronizers plus one history flop for edge detection.
    logic [1:0] scl_sync, sda_sync;
    logic       scl_hist, sda_hist;
    logic       s_scl, s_sda;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_hist <= scl_sync[1];
            sda_hist <= sda_sync[1];
        end
    end

    assign s_scl = scl_sync[1];
    assign s_sda = sda_sync[1];

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  s_scl & ~scl_hist;
    assign scl_fall  = ~s_scl &  scl_hist;
    assign start_det =  s_scl &  scl_hist & sda_hist & ~s_sda;
    assign stop_det  =  s_scl &  scl_hist & ~sda_hist & s_sda;

    state_t     state, state_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic [7:0] shreg, shreg_d;
    logic [1:0] rl_cnt, rl_cnt_d;
    logic       rw, rw_d;
    logic       pend, pend_d;
    logic       sda_oe_d, we_d, re_d, busy_d;
    logic [7:0] addr_d, wdata_d;
    logic [7:0] byte_in;
    logic       last_bit;

    assign byte_in  = {shreg[6:0], s_sda};
    assign last_bit = (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            rl_cnt    <= 2'd0;
            rw        <= 1'b0;
            pend      <= 1'b0;
            sda_oe    <= 1'b0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            shreg     <= shreg_d;
            rl_cnt    <= rl_cnt_d;
            rw        <= rw_d;
            pend      <= pend_d;
            sda_oe    <= sda_oe_d;
            reg_we    <= we_d;
            reg_re    <= re_d;
            busy      <= busy_d;
            reg_addr  <= addr_d;
            reg_wdata <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        rl_cnt_d  = rl_cnt;
        rw_d      = rw;
        pend_d    = pend;
        sda_oe_d  = sda_oe;
        we_d      = 1'b0;
        re_d      = 1'b0;
        busy_d    = busy;
        addr_d    = reg_addr;
        wdata_d   = reg_wdata;

        if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state)
                S_ADDR: if (scl_rise) begin
                    shreg_d   = byte_in;
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (last_bit) begin
                        if (byte_in[7:1] == ADDR) begin
                            state_d = S_ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = byte_in[0];
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end

                S_PTR, S_WDATA: if (scl_rise) begin
                    shreg_d   = byte_in;
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (last_bit) begin
                        if (state == S_PTR) begin
                            addr_d  = byte_in;
                            state_d = S_PTR_ACK;
                        end else begin
                            wdata_d = byte_in;
                            we_d    = 1'b1;
                            state_d = S_WDATA_ACK;
                        end
                    end
                end

                // First falling edge drives the ACK low, the next one ends it.
                // sda_oe is always 0 on entry, so it doubles as the phase flag.
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        rl_cnt_d  = 2'd0;
                        if (state == S_ADDR_ACK)
                            state_d = rw ? S_RLOAD : S_PTR;
                        else
                            state_d = S_WDATA;
                        if (state == S_WDATA_ACK)
                            addr_d = reg_addr + 8'd1;
                    end
                end

                // Cycle 0 raises reg_re, cycle 1 holds it, cycle 2 captures data.
                S_RLOAD: begin
                    rl_cnt_d = rl_cnt + 2'd1;
                    if (rl_cnt == 2'd0)
                        re_d = 1'b1;
                    if (rl_cnt == 2'd2) begin
                        shreg_d   = reg_rdata;
                        bit_cnt_d = 3'd0;
                        rl_cnt_d  = 2'd0;
                        state_d   = S_RDATA;
                        // After the address ACK SCL is already low, so the MSB
                        // goes out now; after a controller ACK SCL is still high
                        // and the MSB must wait for the next falling edge.
                        if (!s_scl) begin
                            sda_oe_d = ~reg_rdata[7];
                            pend_d   = 1'b0;
                        end else begin
                            pend_d   = 1'b1;
                        end
                    end
                end

                S_RDATA: if (scl_fall) begin
                    if (pend) begin
                        sda_oe_d = ~shreg[7];
                        pend_d   = 1'b0;
                    end else if (last_bit) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_RACK;
                    end else begin
                        shreg_d   = {shreg[6:0], 1'b0};
                        sda_oe_d  = ~shreg[6];
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end

                // The pointer advances past every byte sent, ACKed or not, so
                // it always points at the next unread register.
                S_RACK: if (scl_rise) begin
                    addr_d = reg_addr + 8'd1;
                    if (!s_sda) begin
                        state_d  = S_RLOAD;
                        rl_cnt_d = 2'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C controller drives the pads,
// a combinational register model answers reads with addr ^ 8'hFF, and a
// negedge monitor records write/read strobes.
module tb_i2c_target;

    localparam int T = 10;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_drv = 1'b1;
    logic       ctl_low = 1'b0;
    logic       sda_bus;
    logic       sda_oe, reg_we, reg_re, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    assign sda_bus   = ~ctl_low & ~sda_oe;
    assign reg_rdata = reg_addr ^ 8'hFF;

    i2c_target dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_drv),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .reg_re    (reg_re),
        .busy      (busy)
    );

    always #41 clk = ~clk;

    // Strobe monitor
    int         we_cnt = 0, re_cnt = 0, clash = 0, oe_cnt = 0;
    logic [7:0] we_addr [32];
    logic [7:0] we_data [32];

    always @(negedge clk) begin
        if (reg_we) begin
            we_addr[we_cnt % 32] = reg_addr;
            we_data[we_cnt % 32] = reg_wdata;
            we_cnt++;
        end
        if (reg_re) re_cnt++;
        if (reg_we && reg_re) clash++;
        if (sda_oe) oe_cnt++;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tq();
        repeat (T) @(posedge clk);
    endtask

    task automatic i2c_start();
        ctl_low = 1'b0; tq();
        scl_drv = 1'b1; tq();
        ctl_low = 1'b1; tq();
        scl_drv = 1'b0; tq();
    endtask

    task automatic i2c_stop();
        ctl_low = 1'b1; tq();
        scl_drv = 1'b1; tq();
        ctl_low = 1'b0; tq();
    endtask

    task automatic write_bit(input logic b);
        ctl_low = ~b; tq();
        scl_drv = 1'b1; tq(); tq();
        scl_drv = 1'b0; tq();
    endtask

    task automatic read_bit(output logic b);
        ctl_low = 1'b0; tq();
        scl_drv = 1'b1; tq();
        b = sda_bus; tq();
        scl_drv = 1'b0; tq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack_n);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack_n);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    initial begin
        logic       a, b;
        logic [7:0] rb;
        int         w0, r0, o0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_sda_oe", sda_oe, 0);
        check("rst_we", reg_we, 0);
        check("rst_re", reg_re, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", reg_addr, 8'h00);
        check("rst_wdata", reg_wdata, 8'h00);
        @(negedge clk) reset = 1'b0;
        tq();

        // Write: S 84 10 AA 55 P
        w0 = we_cnt;
        i2c_start();
        write_byte(8'h84, a); check("wr_ack_addr", a, 0);
        check("wr_busy", busy, 1);
        write_byte(8'h10, a); check("wr_ack_ptr", a, 0);
        write_byte(8'hAA, a); check("wr_ack_d0", a, 0);
        write_byte(8'h55, a); check("wr_ack_d1", a, 0);
        i2c_stop();
        check("wr_busy_stop", busy, 0);
        check("wr_we_count", we_cnt - w0, 2);
        check("wr_we0_addr", we_addr[w0 % 32], 8'h10);
        check("wr_we0_data", we_data[w0 % 32], 8'hAA);
        check("wr_we1_addr", we_addr[(w0 + 1) % 32], 8'h11);
        check("wr_we1_data", we_data[(w0 + 1) % 32], 8'h55);
        check("wr_ptr_after", reg_addr, 8'h12);

        // Read with repeated START: S 84 20 Sr 85 rd x3 P
        w0 = we_cnt; r0 = re_cnt;
        i2c_start();
        write_byte(8'h84, a); check("rd_ack_addr", a, 0);
        write_byte(8'h20, a); check("rd_ack_ptr", a, 0);
        i2c_start();
        write_byte(8'h85, a); check("rd_ack_addr_r", a, 0);
        check("rd_busy", busy, 1);
        read_byte(rb, 1'b0); check("rd_byte0", rb, 8'hDF);
        read_byte(rb, 1'b0); check("rd_byte1", rb, 8'hDE);
        read_byte(rb, 1'b1); check("rd_byte2", rb, 8'hDD);
        i2c_stop();
        check("rd_ptr_after", reg_addr, 8'h23);
        check("rd_re_count", re_cnt - r0, 3);
        check("rd_no_we", we_cnt - w0, 0);
        check("rd_busy_stop", busy, 0);

        // Address mismatch: S 86 10 P
        w0 = we_cnt; o0 = oe_cnt;
        i2c_start();
        write_byte(8'h86, a); check("mm_nack_addr", a, 1);
        check("mm_busy", busy, 0);
        write_byte(8'h10, a); check("mm_nack_ptr", a, 1);
        i2c_stop();
        check("mm_oe_cycles", oe_cnt - o0, 0);
        check("mm_no_we", we_cnt - w0, 0);
        check("mm_ptr_kept", reg_addr, 8'h23);

        // Pointer wrap: S 84 FF 01 02 P
        w0 = we_cnt;
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'hFF, a);
        write_byte(8'h01, a);
        write_byte(8'h02, a); check("wrap_ack", a, 0);
        i2c_stop();
        check("wrap_we_count", we_cnt - w0, 2);
        check("wrap_we0_addr", we_addr[w0 % 32], 8'hFF);
        check("wrap_we0_data", we_data[w0 % 32], 8'h01);
        check("wrap_we1_addr", we_addr[(w0 + 1) % 32], 8'h00);
        check("wrap_we1_data", we_data[(w0 + 1) % 32], 8'h02);
        check("wrap_ptr_after", reg_addr, 8'h01);

        // Abort: STOP after 4 data bits
        w0 = we_cnt;
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'h30, a);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_stop();
        check("abort_no_we", we_cnt - w0, 0);
        check("abort_sda_oe", sda_oe, 0);
        check("abort_busy", busy, 0);
        i2c_start();
        write_byte(8'h84, a); check("abort_next_ack", a, 0);
        i2c_stop();

        // Reset while driving a 0 read bit: pointer 0x30 -> data 0xCF, bit5 = 0
        i2c_start();
        write_byte(8'h85, a); check("rst_rd_ack", a, 0);
        read_bit(b); check("rst_rd_bit7", b, 1);
        read_bit(b); check("rst_rd_bit6", b, 1);
        check("rst_rd_driving", sda_oe, 1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_sda_oe", sda_oe, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_addr", reg_addr, 8'h00);
        check("rst_mid_wdata", reg_wdata, 8'h00);
        check("rst_mid_we", reg_we, 0);
        check("rst_mid_re", reg_re, 0);
        @(negedge clk) reset = 1'b0;
        tq();
        i2c_stop();
        check("we_re_clash", clash, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
